// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
//
// After reset the pipe is held for INIT_CYC cycles with the PC frozen and
// every latch loading bubbles. After that, each cycle is decoded from the
// state and the current hazard inputs. In priority order, these are:
// data-memory wait (full freeze), taken branch (flush IF/ID, ID/EX and EX/MEM),
// load-use (one bubble into ID/EX), and normal flow.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   id_rs, id_rt, id_uses_rt  source registers of the instruction in ID
//   ex_mem_read, ex_rd      load in EX and its destination register
//   mem_branch_taken        branch in MEM resolved taken
//   mem_req, mem_ready      data-memory access and completion
//   clr_cnt                 synchronous clear of both counters
//   pc_en, *_en             PC / pipeline latch load enables
//   *_flush                 latch loads a bubble when asserted with its enable
//   state                   0 INIT, 1 RUN, 2 WAIT_MEM
//   stall_cnt, flush_cnt    saturating performance counters
module pipeline_ctrl #(
  parameter int unsigned INIT_CYC = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned   IW        = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_init_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_load_use;
  logic             w_mem_wait;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [4:0]       w_en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [3:0]       w_fl;   // {if_id, id_ex, ex_mem, mem_wb}

  // r0 is hardwired, so a load targeting it never creates a hazard.
  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  // In WAIT_MEM, a dropped mem_req releases the pipe the same way mem_ready
  // does. This lets one wait test serve both RUN and WAIT_MEM.
  assign w_mem_wait = mem_req && !mem_ready;

  always_comb begin
    w_en        = '0;
    w_fl        = '0;
    w_state_nxt = r_state;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_en = 5'b01111;
        w_fl = '1;
        if (r_init_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end
      end
      // RUN and WAIT_MEM share one decode. In RUN a wait enters WAIT_MEM; in
      // WAIT_MEM it stays there. Otherwise the branch / load-use / normal
      // rules apply, and the next state is RUN.
      ST_RUN, ST_WAIT_MEM: begin
        if (w_mem_wait) begin
          w_stall_inc = 1'b1;
          w_state_nxt = ST_WAIT_MEM;
        end else begin
          w_state_nxt = ST_RUN;
          if (mem_branch_taken) begin
            // The ID instruction is squashed, so a load-use match is moot.
            w_en        = '1;
            w_fl        = 4'b1110;
            w_flush_inc = 1'b1;
          end else if (w_load_use) begin
            w_en        = 5'b00111;
            w_fl        = 4'b0100;
            w_stall_inc = 1'b1;
          end else begin
            w_en = '1;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
    if (!rst_n) begin
      w_en = '0;
      w_fl = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= INIT_LAST;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_INIT) && (r_init_cnt != '0)) begin
        r_init_cnt <= r_init_cnt - IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}     = w_en;
  assign {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = w_fl;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl.
//
// Two instances share the same stimulus: a default-width one (CNT_W=16) and
// a narrow one (CNT_W=2), which exercises counter saturation. Expected values
// come from hand-written vectors and from a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int unsigned INIT_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0, clr_cnt = 1'b0;

  logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en;
  logic        a_if_id_fl, a_id_ex_fl, a_ex_mem_fl, a_mem_wb_fl;
  logic [1:0]  a_state;
  logic [15:0] a_stall, a_flush;
  logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en;
  logic        b_if_id_fl, b_id_ex_fl, b_ex_mem_fl, b_mem_wb_fl;
  logic [1:0]  b_state;
  logic [1:0]  b_stall, b_flush;

  always #5 clk = ~clk;

  pipeline_ctrl #(.INIT_CYC(INIT_CYC), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en),
    .ex_mem_en(a_ex_mem_en), .mem_wb_en(a_mem_wb_en),
    .if_id_flush(a_if_id_fl), .id_ex_flush(a_id_ex_fl),
    .ex_mem_flush(a_ex_mem_fl), .mem_wb_flush(a_mem_wb_fl),
    .state(a_state), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipeline_ctrl #(.INIT_CYC(INIT_CYC), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en),
    .ex_mem_en(b_ex_mem_en), .mem_wb_en(b_mem_wb_en),
    .if_id_flush(b_if_id_fl), .id_ex_flush(b_id_ex_fl),
    .ex_mem_flush(b_ex_mem_fl), .mem_wb_flush(b_mem_wb_fl),
    .state(b_state), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  wire [4:0] a_en = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en};
  wire [3:0] a_fl = {a_if_id_fl, a_id_ex_fl, a_ex_mem_fl, a_mem_wb_fl};
  wire [4:0] b_en = {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en};
  wire [3:0] b_fl = {b_if_id_fl, b_id_ex_fl, b_ex_mem_fl, b_mem_wb_fl};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles left in INIT, whether a memory wait is pending,
  // and unbounded event counts (saturation is applied at compare time).
  int m_init_left;
  bit m_wait;
  int m_stall;
  int m_flush;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mrd;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic       clr;
    logic [4:0] en;
    logic [3:0] fl;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_init_left = INIT_CYC;
    m_wait      = 1'b0;
    m_stall     = 0;
    m_flush     = 0;
  endtask

  function automatic bit model_freeze();
    return mem_req && !mem_ready;
  endfunction

  function automatic void model_decode(output logic [4:0] en, output logic [3:0] fl,
                                       output bit stall, output bit flush);
    bit hazard;
    en = '0; fl = '0; stall = 1'b0; flush = 1'b0;
    hazard = ex_mem_read && (ex_rd != 0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    if (rst_n) begin
      if (m_init_left > 0) begin
        en = 5'b01111; fl = 4'b1111;
      end else if (model_freeze()) begin
        stall = 1'b1;
      end else if (mem_branch_taken) begin
        en = 5'b11111; fl = 4'b1110; flush = 1'b1;
      end else if (hazard) begin
        en = 5'b00111; fl = 4'b0100; stall = 1'b1;
      end else begin
        en = 5'b11111;
      end
    end
  endfunction

  function automatic int model_state();
    return (m_init_left > 0) ? 0 : (m_wait ? 2 : 1);
  endfunction

  task automatic model_step();
    logic [4:0] en;
    logic [3:0] fl;
    bit st, fs;
    model_decode(en, fl, st, fs);
    if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      m_wait = model_freeze();
    end
    if (clr_cnt) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_stall += int'(st);
      m_flush += int'(fs);
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] en;
    logic [3:0] fl;
    bit st, fs;
    model_decode(en, fl, st, fs);
    chk({tag, "_en"},      32'(a_en),    32'(en));
    chk({tag, "_flush"},   32'(a_fl),    32'(fl));
    chk({tag, "_en2"},     32'(b_en),    32'(en));
    chk({tag, "_flush2"},  32'(b_fl),    32'(fl));
    chk({tag, "_state"},   32'(a_state), model_state());
    chk({tag, "_state2"},  32'(b_state), model_state());
    chk({tag, "_stall"},   32'(a_stall), sat(m_stall, 16));
    chk({tag, "_flushc"},  32'(a_flush), sat(m_flush, 16));
    chk({tag, "_stall2"},  32'(b_stall), sat(m_stall, 2));
    chk({tag, "_flushc2"}, 32'(b_flush), sat(m_flush, 2));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mrd, input logic [4:0] rd, input logic br,
                       input logic req, input logic rdy, input logic clr);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mrd; ex_rd = rd;
    mem_branch_taken = br; mem_req = req; mem_ready = rdy; clr_cnt = clr;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                              input logic mrd, input logic [4:0] rd, input logic br,
                              input logic req, input logic rdy, input logic [4:0] en,
                              input logic [3:0] fl, input logic [1:0] st);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses; v.mrd = mrd; v.rd = rd; v.br = br;
    v.req = req; v.rdy = rdy; v.clr = 1'b0; v.en = en; v.fl = fl; v.st = st;
    return v;
  endfunction

  initial begin
    // Consecutive RUN-state vectors; st is the state during that cycle.
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b11111, 4'b0000, 2'd1)); // normal
    tbl.push_back(mk(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 5'b00111, 4'b0100, 2'd1)); // load-use rs
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b11111, 4'b0000, 2'd1)); // released
    tbl.push_back(mk(5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 5'b11111, 4'b0000, 2'd1)); // rd=0
    tbl.push_back(mk(5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 0, 5'b11111, 4'b0000, 2'd1)); // rt unused
    tbl.push_back(mk(5'd1, 5'd7, 1, 1, 5'd7, 0, 0, 0, 5'b00111, 4'b0100, 2'd1)); // load-use rt
    tbl.push_back(mk(5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, 5'b11111, 4'b1110, 2'd1)); // branch+ld-use
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 5'b00000, 4'b0000, 2'd1)); // wait enters
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 5'b00000, 4'b0000, 2'd2)); // wait holds
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 1, 5'b11111, 4'b1110, 2'd2)); // ready+branch
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 5'b11111, 4'b0000, 2'd1)); // req+ready
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 5'b00000, 4'b0000, 2'd1)); // wait enters
    tbl.push_back(mk(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 5'b00111, 4'b0100, 2'd2)); // req drop+ld-use
    tbl.push_back(mk(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b11111, 4'b0000, 2'd1)); // back to run

    model_reset();
    idle();
    #2;
    chk("rst_en", 32'(a_en), 32'd0);
    chk("rst_flush", 32'(a_fl), 32'd0);
    check_all("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < int'(INIT_CYC); i++) begin
      #2;
      chk("init_en", 32'(a_en), 32'h0F);
      chk("init_flush", 32'(a_fl), 32'h0F);
      chk("init_state", 32'(a_state), 32'd0);
      check_all("init");
      mem_req = 1'b1;             // inputs are ignored during INIT
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
      tick();
      idle();
    end
    #2;
    chk("post_init_state", 32'(a_state), 32'd1);
    chk("post_init_en", 32'(a_en), 32'h1F);
    chk("post_init_stall", 32'(a_stall), 32'd0);
    check_all("post_init");
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].mrd, tbl[i].rd,
            tbl[i].br, tbl[i].req, tbl[i].rdy, tbl[i].clr);
      #2;
      chk($sformatf("tbl%0d_en", i), 32'(a_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_flush", i), 32'(a_fl), 32'(tbl[i].fl));
      chk($sformatf("tbl%0d_state", i), 32'(a_state), 32'(tbl[i].st));
      check_all("tbl");
      tick();
    end

    // Three-cycle memory wait, then release.
    idle(); clr_cnt = 1'b1; #2; check_all("clr"); tick();
    for (int k = 0; k < 3; k++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      chk("mw_en", 32'(a_en), 32'd0);
      chk("mw_state", 32'(a_state), (k == 0) ? 32'd1 : 32'd2);
      check_all("mw");
      tick();
    end
    mem_ready = 1'b1;
    #2;
    chk("mw_rel_en", 32'(a_en), 32'h1F);
    chk("mw_rel_state", 32'(a_state), 32'd2);
    tick();
    idle();
    #2;
    chk("mw_after_state", 32'(a_state), 32'd1);
    chk("mw_stall", 32'(a_stall), 32'd3);
    chk("mw_stall2", 32'(b_stall), 32'd3);
    check_all("mw_after");
    tick();

    // Saturation of the narrow counter, then clear.
    clr_cnt = 1'b1; #2; tick(); idle();
    for (int k = 0; k < 5; k++) begin
      drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("sat_lu_en", 32'(a_en), 32'h07);
      check_all("sat");
      tick();
    end
    idle();
    #2;
    chk("sat_stall2", 32'(b_stall), 32'd3);
    chk("sat_stall", 32'(a_stall), 32'd5);
    clr_cnt = 1'b1;
    tick();
    idle();
    #2;
    chk("clr_stall", 32'(a_stall), 32'd0);
    chk("clr_stall2", 32'(b_stall), 32'd0);
    tick();

    // Asynchronous reset in the middle of WAIT_MEM.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2; check_all("arst_pre"); tick();
    #2;
    chk("arst_wait_state", 32'(a_state), 32'd2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_en", 32'(a_en), 32'd0);
    chk("arst_flush", 32'(a_fl), 32'd0);
    chk("arst_state", 32'(a_state), 32'd0);
    check_all("arst");
    tick();
    rst_n = 1'b1;
    idle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
      #2;
      check_all("rnd");
      if ($urandom_range(0, 255) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline.
- Generates enable and flush for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB latches (including the WB latch carrying reg_write/mem_to_reg).
- Resolves load-use hazards, taken-branch flushes and data-memory wait states.
- Holds the pipeline in a bubble-clearing init sequence after reset.
- Keeps saturating stall/flush performance counters.

Parameters:
INIT_CYC, 4, cycles the pipe is held frozen and flushed after reset release (>=1)
CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of instruction in EX
mem_branch_taken  in  1  branch in MEM resolved taken (branch & zero)
mem_req  in  1  MEM stage accessing data memory this cycle
mem_ready  in  1  data memory completes access this cycle
clr_cnt  in  1  synchronous clear of both counters
pc_en  out  1  PC load enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  latch load enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  latch loads bubble (all controls 0) when asserted with its enable
state  out  2  current FSM state (debug): 0 INIT, 1 RUN, 2 WAIT_MEM
stall_cnt  out  CNT_W  stall cycles seen
flush_cnt  out  CNT_W  branch flushes seen

Behaviour:
- State register and counters are flopped. All en/flush outputs are combinational decode of state plus the current-cycle inputs, so a hazard acts in the same cycle.
- rst_n low (asynchronous, any time, including mid-stall): state=INIT, init counter=INIT_CYC-1, stall_cnt=flush_cnt=0.
- Outputs while rst_n is low: all en=0, all flush=0.
- INIT:
  - pc_en=0.
  - All four latch en=1 and all four flush=1, so the latches fill with bubbles.
  - Init counter decrements each cycle; when it is 0, next state is RUN.
  - Exactly INIT_CYC cycles are spent in INIT.
  - Inputs are ignored and counters do not increment.
- RUN decode, priority highest first:
  1. Mem wait (mem_req=1, mem_ready=0): all en=0, all flush=0 (full freeze); next=WAIT_MEM; stall_cnt+1.
  2. Branch (mem_branch_taken=1): all en=1; if_id_flush=id_ex_flush=ex_mem_flush=1, mem_wb_flush=0; flush_cnt+1. Load-use is ignored because the ID instruction is squashed.
  3. Load-use (ex_mem_read=1, ex_rd!=0, and ex_rd==id_rs or (id_uses_rt=1 and ex_rd==id_rt)): pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; stall_cnt+1. Exactly one bubble is inserted; the next cycle re-evaluates.
  4. Otherwise: all en=1, all flush=0.
- WAIT_MEM:
  - mem_ready=0: full freeze; stall_cnt+1; stay.
  - mem_ready=1: apply RUN rules 2-4 this cycle (rule 1 is skipped); next=RUN.
  - mem_req dropping while in WAIT_MEM is treated as mem_ready=1.
- A flush is never asserted with its en=0, except during reset when both are 0.
- Counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - clr_cnt=1 zeroes both at the clock edge and wins over a same-cycle increment.
- rd=0 never causes a stall (r0 is hardwired).

Test Plan:
- Reset, INIT_CYC=4 -> 4 cycles with pc_en=0 and all latch en=1/flush=1, state=0; 5th cycle state=1, all en=1, flush=0, counters 0.
- RUN, ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> 3 freeze cycles, state=2 on cycles 2-3, release on 4th, stall_cnt=3.
- mem_branch_taken=1 together with a load-use match -> if_id/id_ex/ex_mem flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- mem_ready rises while in WAIT_MEM in the same cycle as mem_branch_taken=1 -> branch flush outputs that cycle, state returns to 1.
- CNT_W=2, 5 load-use stalls -> stall_cnt holds 3. clr_cnt pulse -> 0. rst_n low mid-WAIT_MEM -> outputs 0 immediately, state=0.
